// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU opcode encodings (also used by the ID decode tables)
// and the pipeline stage record carried through EX, MEM and WB.
package ex_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SLL = 8'h7C;
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_SRA = 8'h03;

    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic [ADDR_W-1:0] wd;
        logic [DATA_W-1:0] result;
        logic [7:0]        aluop;
        logic [2:0]        alusel;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
    } stage_t;

    // A stage produces a register write only for a real op that targets a register other than $0.
    function automatic logic stage_writes(input stage_t s);
        return s.valid & s.wreg & (s.wd != '0);
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational EX-stage ALU: logic and shift classes; anything else reports legal=0 with a zero result.
module ex_alu
    import ex_pkg::*;
(
    input  logic [7:0]        aluop,
    input  logic [2:0]        alusel,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    output logic [DATA_W-1:0] result,
    output logic              legal
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        result = '0;
        legal  = 1'b0;
        case (alusel)
            SEL_LOGIC: begin
                case (aluop)
                    OP_AND: begin result = reg1 & reg2;    legal = 1'b1; end
                    OP_OR:  begin result = reg1 | reg2;    legal = 1'b1; end
                    OP_XOR: begin result = reg1 ^ reg2;    legal = 1'b1; end
                    OP_NOR: begin result = ~(reg1 | reg2); legal = 1'b1; end
                    default: ;
                endcase
            end
            SEL_SHIFT: begin
                // Shift amount comes from reg1[4:0]; the data being shifted is reg2.
                case (aluop)
                    OP_SLL: begin result = reg2 << reg1[4:0]; legal = 1'b1; end
                    OP_SRL: begin result = reg2 >> reg1[4:0]; legal = 1'b1; end
                    OP_SRA: begin result = $unsigned($signed(reg2) >>> reg1[4:0]); legal = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_wb_pipe.sv
// Back half of the MIPS core: EX, MEM and WB pipeline registers feeding the register-file write
// port, with per-stage forwarding taps and an illegal-op pulse.
module ex_wb_pipe
    import ex_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [7:0]    aluop_i,
    input  logic [2:0]    alusel_i,
    input  logic [DW-1:0] reg1_i,
    input  logic [DW-1:0] reg2_i,
    input  logic          wreg_i,
    input  logic [AW-1:0] wd_i,
    input  logic          stall_i,
    input  logic          flush_i,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [DW-1:0] wdata_o,
    output logic          ex_fwd_we_o,
    output logic [AW-1:0] ex_fwd_addr_o,
    output logic [DW-1:0] ex_fwd_data_o,
    output logic          mem_fwd_we_o,
    output logic [AW-1:0] mem_fwd_addr_o,
    output logic [DW-1:0] mem_fwd_data_o,
    output logic          illegal_o
);

    stage_t            id_stage;
    stage_t            ex_q;
    stage_t            ex_out;
    stage_t            mem_q;
    stage_t            wb_q;
    logic              ex_held_q;
    logic [DW-1:0]     alu_result;
    logic              alu_legal;

    always_comb begin
        id_stage        = '0;
        id_stage.valid  = valid_i;
        id_stage.wreg   = wreg_i;
        id_stage.wd     = wd_i;
        id_stage.aluop  = aluop_i;
        id_stage.alusel = alusel_i;
        id_stage.reg1   = reg1_i;
        id_stage.reg2   = reg2_i;
    end

    ex_alu u_alu (
        .aluop  (ex_q.aluop),
        .alusel (ex_q.alusel),
        .reg1   (ex_q.reg1),
        .reg2   (ex_q.reg2),
        .result (alu_result),
        .legal  (alu_legal)
    );

    // An unsupported op keeps travelling as a non-writing instruction.
    always_comb begin
        ex_out        = ex_q;
        ex_out.result = alu_result;
        ex_out.wreg   = ex_q.wreg & alu_legal;
    end

    // NOTE: non-blocking assignments throughout so every stage samples its predecessor's old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_held_q <= 1'b0;
        end else if (flush_i) begin
            // The ops in EX and MEM are both killed, so neither may reach WB; the op
            // already in WB has written during this cycle.
            ex_q.valid  <= 1'b0;
            mem_q.valid <= 1'b0;
            wb_q.valid  <= 1'b0;
            ex_held_q   <= 1'b0;
        end else if (stall_i) begin
            mem_q.valid <= 1'b0;
            wb_q        <= mem_q;
            ex_held_q   <= 1'b1;
        end else begin
            ex_q      <= id_stage;
            mem_q     <= ex_out;
            wb_q      <= mem_q;
            ex_held_q <= 1'b0;
        end
    end

    assign we_o           = stage_writes(wb_q);
    assign waddr_o        = wb_q.wd;
    assign wdata_o        = wb_q.result;

    assign ex_fwd_we_o    = stage_writes(ex_out);
    assign ex_fwd_addr_o  = ex_q.wd;
    assign ex_fwd_data_o  = alu_result;

    assign mem_fwd_we_o   = stage_writes(mem_q);
    assign mem_fwd_addr_o = mem_q.wd;
    assign mem_fwd_data_o = mem_q.result;

    // A stalled illegal op is reported only on its first EX cycle.
    assign illegal_o = ex_q.valid & ~alu_legal & ~ex_held_q;

endmodule

// File: tb/tb_ex_wb_pipe.sv
// Self-checking bench for ex_wb_pipe: directed vector table, stall/flush/reset sequences and a
// randomized stream compared against an arithmetic reference model.
module tb_ex_wb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        wreg_i;
    logic [4:0]  wd_i;
    logic        stall_i;
    logic        flush_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        ex_fwd_we_o;
    logic [4:0]  ex_fwd_addr_o;
    logic [31:0] ex_fwd_data_o;
    logic        mem_fwd_we_o;
    logic [4:0]  mem_fwd_addr_o;
    logic [31:0] mem_fwd_data_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_wb_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .aluop_i        (aluop_i),
        .alusel_i       (alusel_i),
        .reg1_i         (reg1_i),
        .reg2_i         (reg2_i),
        .wreg_i         (wreg_i),
        .wd_i           (wd_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .we_o           (we_o),
        .waddr_o        (waddr_o),
        .wdata_o        (wdata_o),
        .ex_fwd_we_o    (ex_fwd_we_o),
        .ex_fwd_addr_o  (ex_fwd_addr_o),
        .ex_fwd_data_o  (ex_fwd_data_o),
        .mem_fwd_we_o   (mem_fwd_we_o),
        .mem_fwd_addr_o (mem_fwd_addr_o),
        .mem_fwd_data_o (mem_fwd_data_o),
        .illegal_o      (illegal_o)
    );

    typedef struct {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        exp_illegal;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd);
        valid_i = 1'b1; aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b;
        wreg_i = 1'b1; wd_i = wd;
    endtask

    task automatic idle();
        valid_i = 1'b0; aluop_i = '0; alusel_i = '0; reg1_i = '0; reg2_i = '0;
        wreg_i = 1'b0; wd_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".we"}, 32'(we_o), 0);
        check({tag, ".waddr"}, 32'(waddr_o), 0);
        check({tag, ".wdata"}, wdata_o, 0);
        check({tag, ".ex_fwd_we"}, 32'(ex_fwd_we_o), 0);
        check({tag, ".mem_fwd_we"}, 32'(mem_fwd_we_o), 0);
        check({tag, ".mem_fwd_data"}, mem_fwd_data_o, 0);
        check({tag, ".illegal"}, 32'(illegal_o), 0);
    endtask

    // Reference ALU from the op definitions: returns {legal, result}.
    function automatic logic [32:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        logic        ok;
        sh = a % 32;
        r  = 32'h0;
        ok = 1'b0;
        if (sel == 3'b001) begin
            ok = 1'b1;
            case (op)
                8'h24:   r = a & b;
                8'h25:   r = a | b;
                8'h26:   r = a ^ b;
                8'h27:   r = ~(a | b);
                default: ok = 1'b0;
            endcase
        end else if (sel == 3'b010) begin
            ok = 1'b1;
            case (op)
                8'h7C:   r = b * (32'd1 << sh);
                8'h02:   r = b / (32'd1 << sh);
                8'h03:   r = (b / (32'd1 << sh)) | (b[31] ? ~(32'hFFFF_FFFF / (32'd1 << sh)) : 32'h0);
                default: ok = 1'b0;
            endcase
        end
        return {ok, r};
    endfunction

    localparam int NV = 12;
    localparam int NR = 200;
    vec_t vecs[NV];

    logic        exp_we   [0:NR+4];
    logic [4:0]  exp_addr [0:NR+4];
    logic [31:0] exp_data [0:NR+4];
    logic        exp_exfw [0:NR+4];
    logic        exp_memfw[0:NR+4];
    logic        exp_ill  [0:NR+4];

    initial begin
        vecs[0]  = '{8'h25, 3'b001, 32'h0000_1234, 32'h0000_00F0, 5'd5,  1'b0, 1'b1, 32'h0000_12F4};
        vecs[1]  = '{8'h03, 3'b010, 32'h0000_0004, 32'h8000_0000, 5'd7,  1'b0, 1'b1, 32'hF800_0000};
        vecs[2]  = '{8'h7C, 3'b010, 32'h0000_001F, 32'h0000_0001, 5'd9,  1'b0, 1'b1, 32'h8000_0000};
        vecs[3]  = '{8'h25, 3'b001, 32'h0000_1234, 32'h0000_00F0, 5'd0,  1'b0, 1'b0, 32'h0000_12F4};
        vecs[4]  = '{8'hFF, 3'b001, 32'h1111_1111, 32'h2222_2222, 5'd6,  1'b1, 1'b0, 32'h0};
        vecs[5]  = '{8'h24, 3'b001, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd1,  1'b0, 1'b1, 32'h0F00_0F00};
        vecs[6]  = '{8'h26, 3'b001, 32'hAAAA_5555, 32'hFFFF_0000, 5'd2,  1'b0, 1'b1, 32'h5555_5555};
        vecs[7]  = '{8'h27, 3'b001, 32'h0000_0000, 32'h0000_0000, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[8]  = '{8'h02, 3'b010, 32'h0000_0008, 32'h8000_0000, 5'd3,  1'b0, 1'b1, 32'h0080_0000};
        vecs[9]  = '{8'h25, 3'b100, 32'h0000_0001, 32'h0000_0002, 5'd4,  1'b1, 1'b0, 32'h0};
        vecs[10] = '{8'h7C, 3'b010, 32'hFFFF_FFE4, 32'h0000_0003, 5'd4,  1'b0, 1'b1, 32'h0000_0030};
        vecs[11] = '{8'h03, 3'b010, 32'h0000_0004, 32'h7000_0000, 5'd8,  1'b0, 1'b1, 32'h0700_0000};

        idle();
        stall_i = 1'b0;
        flush_i = 1'b0;
        rst = 1'b1;
        #3 rst = 1'b0;
        #2 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors, one op at a time into an empty pipeline.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].aluop, vecs[i].alusel, vecs[i].reg1, vecs[i].reg2, vecs[i].wd);
            @(negedge clk);
            idle();
            check($sformatf("vec%0d.illegal", i), 32'(illegal_o), 32'(vecs[i].exp_illegal));
            check($sformatf("vec%0d.ex_fwd_we", i), 32'(ex_fwd_we_o), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) check($sformatf("vec%0d.ex_fwd_data", i), ex_fwd_data_o, vecs[i].exp_data);
            @(negedge clk);
            check($sformatf("vec%0d.illegal_gone", i), 32'(illegal_o), 0);
            check($sformatf("vec%0d.mem_fwd_we", i), 32'(mem_fwd_we_o), 32'(vecs[i].exp_we));
            @(negedge clk);
            check($sformatf("vec%0d.we", i), 32'(we_o), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d.waddr", i), 32'(waddr_o), 32'(vecs[i].wd));
                check($sformatf("vec%0d.wdata", i), wdata_o, vecs[i].exp_data);
            end
            @(negedge clk);
            check($sformatf("vec%0d.we_after", i), 32'(we_o), 0);
        end

        // Stall for two cycles: A (wd 3) in EX, B (wd 4) held on the input.
        begin
            logic [9:0] we_exp;
            we_exp = 10'b0001100000;   // bit t: write expected at negedge t (A at 5, B at 6)
            @(negedge clk);
            drive(8'h25, 3'b001, 32'h0000_0100, 32'h0000_0001, 5'd3);
            for (int t = 1; t < 10; t++) begin
                @(negedge clk);
                check($sformatf("stall.we@%0d", t), 32'(we_o), 32'(we_exp[t]));
                if (t == 5) check("stall.addrA", 32'(waddr_o), 3);
                if (t == 5) check("stall.dataA", wdata_o, 32'h0000_0101);
                if (t == 6) check("stall.addrB", 32'(waddr_o), 4);
                if (t == 6) check("stall.dataB", wdata_o, 32'h0000_00FF);
                if (t == 1) drive(8'h26, 3'b001, 32'h0000_00F0, 32'h0000_000F, 5'd4);
                stall_i = (t == 1 || t == 2);
                if (t == 4) idle();
            end
        end

        // Illegal op held by a stall pulses illegal_o only once.
        @(negedge clk);
        drive(8'hFF, 3'b010, 32'h1, 32'h2, 5'd9);
        @(negedge clk);
        idle();
        stall_i = 1'b1;
        check("ill_stall.first", 32'(illegal_o), 1);
        @(negedge clk);
        check("ill_stall.held", 32'(illegal_o), 0);
        @(negedge clk);
        stall_i = 1'b0;
        check("ill_stall.held2", 32'(illegal_o), 0);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("ill_stall.we", 32'(we_o), 0);
        end

        // Flush with stall: ops in EX (C) and MEM (B) die, the op in WB (A) still writes.
        @(negedge clk);
        drive(8'h25, 3'b001, 32'h0000_000A, 32'h0, 5'd10);
        @(negedge clk);
        drive(8'h25, 3'b001, 32'h0000_000B, 32'h0, 5'd11);
        @(negedge clk);
        drive(8'h25, 3'b001, 32'h0000_000C, 32'h0, 5'd12);
        @(negedge clk);
        drive(8'h25, 3'b001, 32'h0000_000D, 32'h0, 5'd13);
        flush_i = 1'b1;
        stall_i = 1'b1;
        check("flush.wbA_we", 32'(we_o), 1);
        check("flush.wbA_addr", 32'(waddr_o), 10);
        @(negedge clk);
        flush_i = 1'b0;
        stall_i = 1'b0;
        idle();
        for (int t = 0; t < 4; t++) begin
            check($sformatf("flush.we@%0d", t), 32'(we_o), 0);
            check($sformatf("flush.memfwd@%0d", t), 32'(mem_fwd_we_o), 0);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a stream.
        drive(8'h25, 3'b001, 32'h1, 32'h2, 5'd5);
        @(negedge clk);
        drive(8'h25, 3'b001, 32'h3, 32'h4, 5'd6);
        @(negedge clk);
        drive(8'hFF, 3'b001, 32'h5, 32'h6, 5'd7);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        idle();
        rst = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check($sformatf("postreset.we@%0d", t), 32'(we_o), 0);
            check($sformatf("postreset.exfwd@%0d", t), 32'(ex_fwd_we_o), 0);
        end

        // Randomized back-to-back stream against the reference model.
        for (int c = 0; c <= NR + 4; c++) begin
            exp_we[c] = 1'b0; exp_addr[c] = '0; exp_data[c] = '0;
            exp_exfw[c] = 1'b0; exp_memfw[c] = 1'b0; exp_ill[c] = 1'b0;
        end
        for (int c = 0; c <= NR + 3; c++) begin
            @(negedge clk);
            check($sformatf("rnd.illegal@%0d", c), 32'(illegal_o), 32'(exp_ill[c]));
            check($sformatf("rnd.exfwd@%0d", c), 32'(ex_fwd_we_o), 32'(exp_exfw[c]));
            check($sformatf("rnd.memfwd@%0d", c), 32'(mem_fwd_we_o), 32'(exp_memfw[c]));
            check($sformatf("rnd.we@%0d", c), 32'(we_o), 32'(exp_we[c]));
            if (exp_we[c]) begin
                check($sformatf("rnd.waddr@%0d", c), 32'(waddr_o), 32'(exp_addr[c]));
                check($sformatf("rnd.wdata@%0d", c), wdata_o, exp_data[c]);
            end
            if (c < NR) begin
                logic [7:0]  op_tbl [8];
                logic [32:0] r;
                logic        writes;
                op_tbl = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'hFF};
                valid_i  = ($urandom_range(0, 9) < 8);
                wreg_i   = ($urandom_range(0, 9) < 9);
                aluop_i  = op_tbl[$urandom_range(0, 7)];
                alusel_i = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
                reg1_i   = $urandom;
                reg2_i   = $urandom;
                wd_i     = 5'($urandom_range(0, 31));
                r = ref_alu(aluop_i, alusel_i, reg1_i, reg2_i);
                writes = valid_i & wreg_i & r[32] & (wd_i != 5'd0);
                exp_ill[c+1]   = valid_i & ~r[32];
                exp_exfw[c+1]  = writes;
                exp_memfw[c+2] = writes;
                exp_we[c+3]    = writes;
                exp_addr[c+3]  = wd_i;
                exp_data[c+3]  = r[31:0];
            end else begin
                idle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
